filtro_fila_ram: RTL and testbench
==================================

Name: filtro_fila_ram

Overview:
- Parametrised, RAM-mastering 3-tap row filter engine; the successor to the fixed 8-bit filter processor.
- On `start`, walks a runtime-sized image (`img_w` x `img_h`) at `src_base`, applies a selectable 3-tap horizontal kernel and writes results to `dst_base`.
- Uses the same single-port RAM handshake: RE/WE strobes, byte/pixel data, 32-bit address.
- Adds configurable pixel width, configurable RAM read latency, four filter modes, border replication and status outputs.

Parameters:
- DATA_W, 8: pixel width in bits.
- ADDR_W, 32: RAM address width.
- DIM_W, 12: width of `img_w`/`img_h`; also bounds the image size.
- RD_LAT, 1: RAM read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  00 copy, 01 blur, 10 sharpen, 11 edge; latched at start.
- src_base  in  ADDR_W  source image base address; latched at start.
- dst_base  in  ADDR_W  destination image base address; latched at start.
- img_w  in  DIM_W  pixels per row; latched at start.
- img_h  in  DIM_W  number of rows; latched at start.
- Data_in_RAM  in  DATA_W  RAM read data; valid RD_LAT cycles after `mem_RE_RAM`.
- mem_RE_RAM  out  1  read strobe.
- mem_WE_RAM  out  1  write strobe.
- Data_Dir_RAM  out  ADDR_W  RAM address.
- Data_RAM  out  DATA_W  RAM write data.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- pix_count  out  2*DIM_W  pixels written in the current/last job.

Behaviour:
- Reset: every output is 0. FSM goes to IDLE; window and latched configuration registers are cleared.
- Reset mid-job aborts immediately. No further strobes are issued; no `done` pulse.
- FSM states: IDLE, FETCH, WAIT, CAPTURE, WRITE, FIN.
  - IDLE + start: latch configuration, clear `pix_count`; busy=1 next cycle.
  - If `img_w`=0 or `img_h`=0: go to FIN directly, with no RAM access.
  - FETCH: `mem_RE_RAM`=1 for exactly 1 cycle, `Data_Dir_RAM` = src address.
  - WAIT: RD_LAT-1 cycles; skipped when RD_LAT=1.
  - CAPTURE: sample `Data_in_RAM` into the window.
  - WRITE: `mem_WE_RAM`=1 for exactly 1 cycle, `Data_Dir_RAM` = dst address, `Data_RAM` = result; `pix_count` increments.
  - FIN: `done`=1 for 1 cycle, busy=0, then IDLE.
- `start` while busy is ignored.
- RE and WE are never high in the same cycle. `Data_Dir_RAM` and `Data_RAM` hold their last values when no strobe is active.
- Window and borders: window (a,b,c) = pixels x-1, x, x+1 of the current row.
  - At row start, read p0 then p1 (p1 only if w>1), giving a=b=p0, c=p1 (or c=p0 if w=1).
  - After each write: a<=b, b<=c. Then, if x+1<w, fetch c=p[x+1]; otherwise c<=b (replication, no read).
  - Each source pixel is read exactly once per job: w*h reads and w*h writes.
  - Rows are independent; no vertical coupling.
- Addressing: linear index i = y*w + x, kept as a running counter (no multiplier). src = src_base+i, dst = dst_base+i, both modulo 2^ADDR_W (wrap allowed).
- Arithmetic; MAX = 2^DATA_W-1:
  - copy: b.
  - blur: (a + 2b + c + 2) >> 2, computed in DATA_W+2 bits.
  - sharpen: 3b - a - c, signed in DATA_W+3 bits, clamped to [0, MAX].
  - edge: |a - c|.
- Overlapping src/dst regions: the engine makes no hazard guarantee, except that src==dst is safe because each pixel is read before its write.

Decomposition:
- Package `filtro_pkg`: mode constants (MODE_COPY/BLUR/SHARP/EDGE), the FSM state enum, and a MAX helper function.
- Sub-module `filtro_alu_3tap` (combinational): parameters DATA_W; inputs a, b, c, mode; output y. Implements all four kernels including clamping. The top level holds the FSM, counters, window and RAM port.

Test Plan:
- Blur, w=4 h=1, row [10,20,30,40], src=0x100 dst=0x200 -> writes 0x200..0x203 = [13,20,30,38]; exactly 4 RE and 4 WE; one `done` pulse; pix_count=4.
- Sharpen, row [0,255,0] -> [0,255,0], clamping both low (-255 -> 0) and high (765 -> 255).
- Edge, row [10,50,20] -> [40,10,30]. Also w=1 with [77] in copy mode -> [77] with a single read.
- Copy, w=3 h=2, src=0x100 dst=0x200, RD_LAT=3 -> data written equals data read at offsets 0..5; each read is sampled exactly 3 cycles after its RE; RE and WE never overlap.
- `img_w`=0 (or `img_h`=0) -> `done` pulses 2 cycles after start; no RE/WE; pix_count=0.
- Start pulsed again while busy -> ignored, with output unchanged. rst_n asserted after 2 writes -> all outputs 0 asynchronously, no `done`; a following job runs correctly from scratch.

Source files
------------

// File: rtl/filtro_pkg.sv
// Shared definitions for the 3-tap row filter: kernel select codes, FSM states and
// a helper for the largest pixel value.
package filtro_pkg;

  localparam logic [1:0] MODE_COPY  = 2'b00;
  localparam logic [1:0] MODE_BLUR  = 2'b01;
  localparam logic [1:0] MODE_SHARP = 2'b10;
  localparam logic [1:0] MODE_EDGE  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_CAPTURE,
    ST_WRITE,
    ST_FIN
  } state_e;

  function automatic logic [31:0] max_val(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/filtro_alu_3tap.sv
// Combinational 3-tap kernel: copy, blur, clamped sharpen and absolute edge on window (a,b,c).
module filtro_alu_3tap
  import filtro_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] y
);

  localparam int BW = DATA_W + 2;
  localparam int SW = DATA_W + 3;
  localparam logic signed [SW-1:0] MAX_S = SW'(max_val(DATA_W));

  logic [BW-1:0]        blur_sum;
  logic signed [SW-1:0] sharp;

  always_comb begin
    blur_sum = BW'(a) + BW'({b, 1'b0}) + BW'(c) + BW'(2);
    // unsigned wrap in SW bits gives the correct two's complement result
    sharp    = SW'(b) + SW'(b) + SW'(b) - SW'(a) - SW'(c);
    y        = b;
    case (mode)
      MODE_COPY:  y = b;
      MODE_BLUR:  y = blur_sum[BW-1:2];
      MODE_SHARP: begin
        if (sharp[SW-1])       y = '0;
        else if (sharp > MAX_S) y = DATA_W'(max_val(DATA_W));
        else                    y = sharp[DATA_W-1:0];
      end
      default:    y = (a >= c) ? (a - c) : (c - a);
    endcase
  end

endmodule

// File: rtl/filtro_fila_ram.sv
// RAM-mastering 3-tap row filter: IDLE -> FETCH -> WAIT -> CAPTURE -> WRITE ... -> FIN.
// Each source pixel is read once; row borders are replicated without extra reads.
module filtro_fila_ram
  import filtro_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 12,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [ADDR_W-1:0]    src_base,
  input  logic [ADDR_W-1:0]    dst_base,
  input  logic [DIM_W-1:0]     img_w,
  input  logic [DIM_W-1:0]     img_h,
  input  logic [DATA_W-1:0]    Data_in_RAM,
  output logic                 mem_RE_RAM,
  output logic                 mem_WE_RAM,
  output logic [ADDR_W-1:0]    Data_Dir_RAM,
  output logic [DATA_W-1:0]    Data_RAM,
  output logic                 busy,
  output logic                 done,
  output logic [2*DIM_W-1:0]   pix_count
);

  localparam int XW = DIM_W + 1;
  localparam int PW = 2 * DIM_W;
  localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_e              state_q;
  logic [1:0]          mode_q;
  logic [DIM_W-1:0]    w_q, h_q, x_q, y_q;
  logic [ADDR_W-1:0]   rd_ptr_q, wr_ptr_q, addr_q;
  logic [1:0]          wait_q;
  logic                first_q, re_q, we_q, busy_q, done_q;
  logic [DATA_W-1:0]   wdata_q, alu_y;
  logic [PW-1:0]       pix_q;
  logic [DATA_W-1:0]   a_q, b_q, c_q, a_d, b_d, c_d;
  logic [XW-1:0]       x_nxt;
  logic                row_end, more_rd, last_row;

  assign x_nxt    = {1'b0, x_q} + XW'(1);
  assign row_end  = (x_nxt == {1'b0, w_q});
  assign more_rd  = ((x_nxt + XW'(1)) < {1'b0, w_q});
  assign last_row = (({1'b0, y_q} + XW'(1)) == {1'b0, h_q});

  // Next window; the ALU sees it so a write can be issued on the same edge it forms.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    if (state_q == ST_CAPTURE) begin
      c_d = Data_in_RAM;
      if (first_q) begin
        a_d = Data_in_RAM;
        b_d = Data_in_RAM;
      end
    end else if (state_q == ST_WRITE) begin
      a_d = b_q;
      b_d = c_q;
      c_d = c_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end

  filtro_alu_3tap #(.DATA_W(DATA_W)) u_alu (
    .a(a_d), .b(b_d), .c(c_d), .mode(mode_q), .y(alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      w_q      <= '0;
      h_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      wait_q   <= '0;
      first_q  <= 1'b0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pix_q    <= '0;
    end else begin
      done_q <= 1'b0;
      re_q   <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          mode_q   <= mode;
          w_q      <= img_w;
          h_q      <= img_h;
          x_q      <= '0;
          y_q      <= '0;
          rd_ptr_q <= src_base;
          wr_ptr_q <= dst_base;
          pix_q    <= '0;
          busy_q   <= 1'b1;
          if (img_w == '0 || img_h == '0) begin
            state_q <= ST_FIN;
          end else begin
            state_q <= ST_FETCH;
            first_q <= 1'b1;
            re_q    <= 1'b1;
            addr_q  <= src_base;
          end
        end
        ST_FETCH: begin
          rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
          wait_q   <= WAIT_INIT;
          state_q  <= (RD_LAT > 1) ? ST_WAIT : ST_CAPTURE;
        end
        ST_WAIT: begin
          if (wait_q == 2'd0) state_q <= ST_CAPTURE;
          else                wait_q  <= wait_q - 2'd1;
        end
        ST_CAPTURE: begin
          first_q <= 1'b0;
          if (first_q && w_q > DIM_W'(1)) begin
            state_q <= ST_FETCH;
            re_q    <= 1'b1;
            addr_q  <= rd_ptr_q;
          end else begin
            state_q <= ST_WRITE;
            we_q    <= 1'b1;
            addr_q  <= wr_ptr_q;
            wdata_q <= alu_y;
          end
        end
        ST_WRITE: begin
          pix_q    <= pix_q + PW'(1);
          wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
          if (row_end) begin
            x_q <= '0;
            if (last_row) begin
              state_q <= ST_FIN;
            end else begin
              y_q     <= y_q + DIM_W'(1);
              first_q <= 1'b1;
              state_q <= ST_FETCH;
              re_q    <= 1'b1;
              addr_q  <= rd_ptr_q;
            end
          end else begin
            x_q <= x_nxt[DIM_W-1:0];
            if (more_rd) begin
              state_q <= ST_FETCH;
              re_q    <= 1'b1;
              addr_q  <= rd_ptr_q;
            end else begin
              // right border: c replicates b, no read needed
              state_q <= ST_WRITE;
              we_q    <= 1'b1;
              addr_q  <= wr_ptr_q + ADDR_W'(1);
              wdata_q <= alu_y;
            end
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_RE_RAM   = re_q;
  assign mem_WE_RAM   = we_q;
  assign Data_Dir_RAM = addr_q;
  assign Data_RAM     = wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pix_count    = pix_q;

endmodule

// File: tb/tb_filtro_fila_ram.sv
// Bench for filtro_fila_ram: latency-modelled RAM, directed vectors and random jobs
// checked against a plain-arithmetic row filter model.
`timescale 1ns/1ps
module tb_filtro_fila_ram;
  import filtro_pkg::*;

  localparam int LAT = 3;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] src_base = '0, dst_base = '0;
  logic [11:0] img_w = '0, img_h = '0;
  logic [7:0]  Data_in_RAM = '0;
  logic        mem_RE_RAM, mem_WE_RAM, busy, done;
  logic [31:0] Data_Dir_RAM;
  logic [7:0]  Data_RAM;
  logic [23:0] pix_count;

  filtro_fila_ram #(.DATA_W(8), .ADDR_W(32), .DIM_W(12), .RD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_base(src_base), .dst_base(dst_base), .img_w(img_w), .img_h(img_h),
    .Data_in_RAM(Data_in_RAM), .mem_RE_RAM(mem_RE_RAM), .mem_WE_RAM(mem_WE_RAM),
    .Data_Dir_RAM(Data_Dir_RAM), .Data_RAM(Data_RAM), .busy(busy), .done(done),
    .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [31:0] addr; } rd_t;
  rd_t         pend[$];
  logic [39:0] wlog[$];
  logic [7:0]  srcmem [logic [31:0]];
  int cyc = 0, re_cnt = 0, we_cnt = 0, done_cnt = 0, overlap_cnt = 0;
  int start_cyc = 0, done_cyc = 0;
  int total = 0, bad = 0;
  int re0, we0, d0, wb;
  int src_px[$], exp_px[$];

  // RAM model and bus monitor; read data appears only in the cycle LAT after RE.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) pend.delete();
    if (mem_RE_RAM && mem_WE_RAM) overlap_cnt++;
    if (mem_RE_RAM) begin re_cnt++; pend.push_back('{cyc, Data_Dir_RAM}); end
    if (mem_WE_RAM) begin we_cnt++; wlog.push_back({Data_Dir_RAM, Data_RAM}); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (start && !busy) start_cyc = cyc;
    if (pend.size() > 0 && pend[0].cyc + LAT == cyc) begin
      Data_in_RAM = srcmem.exists(pend[0].addr) ? srcmem[pend[0].addr] : 8'hxx;
      void'(pend.pop_front());
    end else begin
      Data_in_RAM = 8'($urandom);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int kern(input int m, input int a, input int b, input int c);
    int s;
    case (m)
      0: return b;
      1: return (a + 2 * b + c + 2) / 4;
      2: begin s = 3 * b - a - c; return (s < 0) ? 0 : ((s > 255) ? 255 : s); end
      default: return (a > c) ? a - c : c - a;
    endcase
  endfunction

  task automatic build_model(input int m, input int w, input int h);
    exp_px.delete();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        exp_px.push_back(kern(m, src_px[y*w + ((x > 0) ? x - 1 : 0)], src_px[y*w + x],
                              src_px[y*w + ((x + 1 < w) ? x + 1 : w - 1)]));
  endtask

  task automatic rand_src(input int n);
    src_px.delete();
    for (int i = 0; i < n; i++) src_px.push_back(int'($urandom_range(0, 255)));
  endtask

  task automatic start_job(input logic [1:0] m, input logic [31:0] sb, input logic [31:0] db,
                           input int w, input int h);
    for (int i = 0; i < w * h; i++) srcmem[sb + 32'(i)] = 8'(src_px[i]);
    @(posedge clk); #1;
    mode = m; src_base = sb; dst_base = db; img_w = 12'(w); img_h = 12'(h);
    re0 = re_cnt; we0 = we_cnt; d0 = done_cnt; wb = wlog.size();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == d0 && n < 5000) begin @(negedge clk); #1; n++; end
    check("done_seen", 64'(done_cnt != d0), 1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic finish_job(input string tag, input int w, input int h, input logic [31:0] db);
    logic [39:0] obs;
    check({tag, "/done_pulses"}, done_cnt - d0, 1);
    check({tag, "/reads"}, re_cnt - re0, w * h);
    check({tag, "/writes"}, we_cnt - we0, w * h);
    check({tag, "/overlap"}, overlap_cnt, 0);
    check({tag, "/pix_count"}, pix_count, w * h);
    check({tag, "/busy"}, busy, 0);
    for (int i = 0; i < w * h; i++) begin
      obs = (wb + i < wlog.size()) ? wlog[wb + i] : 40'hxx;
      check({tag, "/wr"}, obs, {db + 32'(i), 8'(exp_px[i])});
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "/re"}, mem_RE_RAM, 0);
    check({tag, "/we"}, mem_WE_RAM, 0);
    check({tag, "/addr"}, Data_Dir_RAM, 0);
    check({tag, "/data"}, Data_RAM, 0);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/done"}, done, 0);
    check({tag, "/pix"}, pix_count, 0);
  endtask

  initial begin
    int n, re_mid, w, h, m;
    logic [31:0] sb, db;

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    src_px = '{10, 20, 30, 40}; exp_px = '{13, 20, 30, 38};
    start_job(MODE_BLUR, 32'h100, 32'h200, 4, 1); wait_done();
    finish_job("blur", 4, 1, 32'h200);

    src_px = '{0, 255, 0}; exp_px = '{0, 255, 0};
    start_job(MODE_SHARP, 32'h100, 32'h200, 3, 1); wait_done();
    finish_job("sharp", 3, 1, 32'h200);

    src_px = '{10, 50, 20}; exp_px = '{40, 10, 30};
    start_job(MODE_EDGE, 32'h100, 32'h200, 3, 1); wait_done();
    finish_job("edge", 3, 1, 32'h200);

    src_px = '{77}; exp_px = '{77};
    start_job(MODE_COPY, 32'h100, 32'h200, 1, 1); wait_done();
    finish_job("w1", 1, 1, 32'h200);

    rand_src(6); build_model(0, 3, 2);
    start_job(MODE_COPY, 32'h100, 32'h200, 3, 2); wait_done();
    finish_job("copy3x2", 3, 2, 32'h200);

    src_px.delete();
    start_job(MODE_COPY, 32'h100, 32'h200, 0, 3); wait_done();
    check("zero_w/latency", done_cyc - start_cyc, 2);
    check("zero_w/reads", re_cnt - re0, 0);
    check("zero_w/writes", we_cnt - we0, 0);
    check("zero_w/pix", pix_count, 0);
    start_job(MODE_BLUR, 32'h100, 32'h200, 5, 0); wait_done();
    check("zero_h/latency", done_cyc - start_cyc, 2);
    check("zero_h/reads", re_cnt - re0, 0);
    check("zero_h/writes", we_cnt - we0, 0);

    rand_src(5); build_model(0, 5, 1);
    start_job(MODE_COPY, 32'h300, 32'h400, 5, 1);
    repeat (4) @(posedge clk);
    #1;
    mode = MODE_EDGE; img_w = 12'd9; src_base = 32'h999; dst_base = 32'h777; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    finish_job("ignore", 5, 1, 32'h400);

    rand_src(16);
    start_job(MODE_BLUR, 32'h500, 32'h600, 8, 2);
    n = 0;
    while (we_cnt - we0 < 2 && n < 500) begin @(negedge clk); #1; n++; end
    check("abort/two_writes", we_cnt - we0, 2);
    re_mid = re_cnt;
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    repeat (6) @(posedge clk);
    #1;
    check("abort/no_reads", re_cnt, re_mid);
    check("abort/no_writes", we_cnt - we0, 2);
    check("abort/no_done", done_cnt - d0, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      m = int'($urandom_range(0, 3));
      w = int'($urandom_range(1, 7));
      h = int'($urandom_range(1, 3));
      sb = (k == 0) ? 32'hFFFF_FFFC : $urandom_range(0, 32'h0FFF_FFFF);
      db = (k == 1) ? 32'hFFFF_FFFE : sb + 32'h0001_0000;
      rand_src(w * h); build_model(m, w, h);
      start_job(2'(m), sb, db, w, h); wait_done();
      finish_job($sformatf("rand%0d", k), w, h, db);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
